// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3-256 pipeline.
// Contents: rate/lane geometry constants, pad-stage FSM encoding, padding byte constants.
// No ports.
package sha3_pkg;

   localparam int unsigned RATE_BITS  = 1088;
   localparam int unsigned LANE_W     = 64;
   localparam int unsigned RATE_LANES = 17;
   localparam int unsigned STATE_BITS = 1600;

   // Pad-stage FSM: FILL collects lanes, EMIT offers a block, PAD builds the extra pad-only block
   typedef enum logic [1:0] {
      StFill = 2'd0,
      StEmit = 2'd1,
      StPad  = 2'd2
   } pad_state_e;

   localparam logic [7:0] SHA3_DOMAIN_BYTE = 8'h06;  // FIPS 202 SHA3 domain + first pad bit
   localparam logic [7:0] KECCAK_PAD_BYTE  = 8'h01;  // original Keccak first pad bit
   localparam logic [7:0] FINAL_PAD_BYTE   = 8'h80;  // closing pad bit in the last rate byte

endpackage

// File: rtl/sha3_lane_pad.sv
// Combinational lane padder: keeps the low nbytes bytes of a lane, zeroes the rest,
// and writes the first padding byte at byte position nbytes (when nbytes < lane bytes).
// Ports:
//   data    in   LANE_W  raw lane, byte k at [8k+7:8k]
//   nbytes  in   4       valid byte count; values above the lane byte count saturate
//   padded  out  LANE_W  masked lane with the padding byte inserted
module sha3_lane_pad #(
   parameter int unsigned LANE_W   = 64,
   parameter logic [7:0]  PAD_BYTE = 8'h06
) (
   input  logic [LANE_W-1:0] data,
   input  logic [3:0]        nbytes,
   output logic [LANE_W-1:0] padded
);

   localparam int unsigned LANE_BYTES = LANE_W / 8;
   localparam logic [3:0]  MAX_BYTES  = 4'(LANE_BYTES);

   logic [3:0] nb_sat;

   always_comb begin
      nb_sat = (nbytes > MAX_BYTES) ? MAX_BYTES : nbytes;
      padded = '0;
      for (int k = 0; k < LANE_BYTES; k++) begin
         if (4'(k) < nb_sat) begin
            padded[8*k +: 8] = data[8*k +: 8];
         end else if (4'(k) == nb_sat) begin
            padded[8*k +: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/sha3_pad_stage.sv
// SHA3 pad stage: assembles 64-bit message lanes into rate blocks, applies multi-rate
// padding and hands blocks to the absorb stage over a valid/ready handshake.
// Build option: define KECCAK_LEGACY_PAD_EN to use 8'h01 (original Keccak) as the first
// padding byte instead of DOMAIN_BYTE.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       message lane (valid bytes are the low bytes)
//   in_valid      in_data valid
//   in_last       final lane of the message
//   in_bytes      valid bytes in the final lane (0..8, saturating)
//   in_ready      lane accepted this cycle when high with in_valid
//   block         padded rate block, lane 0 in the top bits
//   block_valid   block offered downstream
//   block_last    block is the final block of the message
//   block_ready   downstream accepts the block
module sha3_pad_stage #(
   parameter int unsigned RATE_LANES  = 17,
   parameter int unsigned LANE_W      = 64,
   parameter logic [7:0]  DOMAIN_BYTE = 8'h06
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [LANE_W-1:0]            in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   input  logic [3:0]                   in_bytes,
   output logic                         in_ready,
   output logic [RATE_LANES*LANE_W-1:0] block,
   output logic                         block_valid,
   output logic                         block_last,
   input  logic                         block_ready
);

   import sha3_pkg::*;

   localparam int unsigned     IDX_W      = $clog2(RATE_LANES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATE_LANES - 1);
   localparam logic [3:0]      FULL_BYTES = 4'(LANE_W / 8);
`ifdef KECCAK_LEGACY_PAD_EN
   localparam logic [7:0]      FIRST_PAD  = KECCAK_PAD_BYTE;
`else
   localparam logic [7:0]      FIRST_PAD  = DOMAIN_BYTE;
`endif

   // Lane i lives at packed index RATE_LANES-1-i so the buffer maps directly onto block
   logic [RATE_LANES-1:0][LANE_W-1:0] lanes_q, lanes_d;
   pad_state_e                        state_q, state_d;
   logic [IDX_W-1:0]                  lane_idx_q, lane_idx_d;
   logic                              last_q, last_d;
   logic                              pad_pending_q, pad_pending_d;

   logic [LANE_W-1:0] pad_src, padded;
   logic [3:0]        pad_nbytes;

   // PAD reuses the padder on an empty lane to get the first pad byte at byte 0
   assign pad_src    = (state_q == StPad) ? '0 : in_data;
   assign pad_nbytes = (state_q == StPad) ? 4'd0 : in_bytes;

   sha3_lane_pad #(
      .LANE_W   (LANE_W),
      .PAD_BYTE (FIRST_PAD)
   ) u_lane_pad (
      .data   (pad_src),
      .nbytes (pad_nbytes),
      .padded (padded)
   );

   assign block      = lanes_q;
   assign block_last = last_q;

   always_comb begin
      state_d       = state_q;
      lane_idx_d    = lane_idx_q;
      lanes_d       = lanes_q;
      last_d        = last_q;
      pad_pending_d = pad_pending_q;
      in_ready      = (state_q == StFill);
      block_valid   = (state_q == StEmit);

      unique case (state_q)
         StFill: begin
            if (in_valid) begin
               if (in_last) begin
                  lanes_d[LAST_IDX - lane_idx_q] = padded;
                  state_d    = StEmit;
                  lane_idx_d = '0;
                  if (lane_idx_q != LAST_IDX || in_bytes < FULL_BYTES) begin
                     lanes_d[0][LANE_W-1 -: 8] = lanes_d[0][LANE_W-1 -: 8] | FINAL_PAD_BYTE;
                     last_d = 1'b1;
                  end else begin
                     // Full final lane closes the block; padding needs a block of its own
                     last_d        = 1'b0;
                     pad_pending_d = 1'b1;
                  end
               end else begin
                  lanes_d[LAST_IDX - lane_idx_q] = in_data;
                  if (lane_idx_q == LAST_IDX) begin
                     state_d    = StEmit;
                     last_d     = 1'b0;
                     lane_idx_d = '0;
                  end else begin
                     lane_idx_d = lane_idx_q + 1'b1;
                  end
               end
            end
         end
         StEmit: begin
            if (block_ready) begin
               lanes_d = '0;
               last_d  = 1'b0;
               if (pad_pending_q) begin
                  state_d = StPad;
               end else begin
                  state_d    = StFill;
                  lane_idx_d = '0;
               end
            end
         end
         StPad: begin
            lanes_d[LAST_IDX] = padded;
            lanes_d[0][LANE_W-1 -: 8] = lanes_d[0][LANE_W-1 -: 8] | FINAL_PAD_BYTE;
            last_d        = 1'b1;
            pad_pending_d = 1'b0;
            state_d       = StEmit;
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StFill;
         lane_idx_q    <= '0;
         lanes_q       <= '0;
         last_q        <= 1'b0;
         pad_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lane_idx_q    <= lane_idx_d;
         lanes_q       <= lanes_d;
         last_q        <= last_d;
         pad_pending_q <= pad_pending_d;
      end
   end

endmodule

// File: tb/tb_sha3_pad_stage.sv
module tb_sha3_pad_stage;

   localparam int BW = 1088;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [63:0]   in_data;
   logic          in_valid;
   logic          in_last;
   logic [3:0]    in_bytes;
   logic          in_ready;
   logic [BW-1:0] block;
   logic          block_valid;
   logic          block_last;
   logic          block_ready;

   int checks = 0;
   int errors = 0;

   sha3_pad_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_bytes    (in_bytes),
      .in_ready    (in_ready),
      .block       (block),
      .block_valid (block_valid),
      .block_last  (block_last),
      .block_ready (block_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  nbytes;
      logic [63:0] lane0;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [BW-1:0] set_lane(input logic [BW-1:0] blk, input int i,
                                              input logic [63:0] v);
      blk[BW-1-64*i -: 64] = v;
      return blk;
   endfunction

   function automatic logic [63:0] get_lane(input logic [BW-1:0] blk, input int i);
      return blk[BW-1-64*i -: 64];
   endfunction

   function automatic logic [63:0] dat(input int i);
      return 64'(i + 1) * 64'h0101_0101_0101_0101;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      bit shown;
      checks++;
      shown = 1'b0;
      if (act !== exp) begin
         errors++;
         for (int i = 0; i < 17; i++) begin
            if (!shown && get_lane(act, i) !== get_lane(exp, i)) begin
               $display("FAIL %s lane %0d: got %h expected %h", name, i, get_lane(act, i),
                        get_lane(exp, i));
               shown = 1'b1;
            end
         end
      end
   endtask

   task automatic send_lane(input logic [63:0] d, input logic l, input logic [3:0] nb);
      int n;
      n = 0;
      in_data  = d;
      in_last  = l;
      in_bytes = nb;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_lane timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic take_block();
      int n;
      n = 0;
      while (!block_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!block_valid) begin
         checks++;
         errors++;
         $display("FAIL take_block timeout: block_valid got 0 expected 1");
      end
      block_ready = 1'b1;
      @(posedge clk);
      #1;
      block_ready = 1'b0;
   endtask

   logic [BW-1:0] exp_blk;
   logic [BW-1:0] exp_blk2;

   initial begin
      vecs[0] = '{data: 64'hFFFF_FFFF_FFFF_FFFF, nbytes: 4'd0, lane0: 64'h0000_0000_0000_0006};
      vecs[1] = '{data: 64'h0000_0000_0063_6261, nbytes: 4'd3, lane0: 64'h0000_0000_0663_6261};
      vecs[2] = '{data: 64'hAABB_CCDD_EEFF_0011, nbytes: 4'd7, lane0: 64'h06BB_CCDD_EEFF_0011};
      vecs[3] = '{data: 64'hDEAD_BEEF_CAFE_BABE, nbytes: 4'd1, lane0: 64'h0000_0000_0000_06BE};
      vecs[4] = '{data: 64'h0123_4567_89AB_CDEF, nbytes: 4'd4, lane0: 64'h0000_0006_89AB_CDEF};

      rst_n       = 1'b0;
      in_data     = '0;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      in_bytes    = '0;
      block_ready = 1'b0;

      #2;
      chk("reset block_valid", 64'(block_valid), 64'd0);
      chk("reset block_last", 64'(block_last), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk_blk("reset block", block, '0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single-lane messages
      for (int v = 0; v < 5; v++) begin
         send_lane(vecs[v].data, 1'b1, vecs[v].nbytes);
         exp_blk = '0;
         exp_blk = set_lane(exp_blk, 0, vecs[v].lane0);
         exp_blk[63:56] = 8'h80;
         chk("single valid latency", 64'(block_valid), 64'd1);
         chk("single in_ready low", 64'(in_ready), 64'd0);
         chk_blk("single block", block, exp_blk);
         chk("single last", 64'(block_last), 64'd1);
         take_block();
         chk("single valid dropped", 64'(block_valid), 64'd0);
      end

      // 17 full lanes, last full: raw block then pad-only block
      exp_blk = '0;
      for (int i = 0; i < 17; i++) begin
         send_lane(dat(i), i == 16, 4'd8);
         exp_blk = set_lane(exp_blk, i, dat(i));
      end
      chk("full valid", 64'(block_valid), 64'd1);
      chk_blk("full raw block", block, exp_blk);
      chk("full first last", 64'(block_last), 64'd0);
      block_ready = 1'b1;
      @(posedge clk);
      #1;
      block_ready = 1'b0;
      chk("pad cycle valid low", 64'(block_valid), 64'd0);
      chk("pad cycle in_ready low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      exp_blk2 = '0;
      exp_blk2 = set_lane(exp_blk2, 0, 64'h06);
      exp_blk2[63:56] = 8'h80;
      chk("pad block valid", 64'(block_valid), 64'd1);
      chk_blk("pad block", block, exp_blk2);
      chk("pad block last", 64'(block_last), 64'd1);
      take_block();
      chk("after pad in_ready", 64'(in_ready), 64'd1);

      // 17th lane last with 7 bytes: domain and final pad share the top byte
      exp_blk = '0;
      for (int i = 0; i < 16; i++) begin
         send_lane(dat(i + 20), 1'b0, 4'd8);
         exp_blk = set_lane(exp_blk, i, dat(i + 20));
      end
      send_lane(64'hFFEE_DDCC_BBAA_9988, 1'b1, 4'd7);
      exp_blk = set_lane(exp_blk, 16, 64'h86EE_DDCC_BBAA_9988);
      chk("byte7 top byte", 64'(block[63:56]), 64'h86);
      chk_blk("byte7 block", block, exp_blk);
      chk("byte7 last", 64'(block_last), 64'd1);
      take_block();
      @(posedge clk);
      #1;
      chk("byte7 no extra block", 64'(block_valid), 64'd0);
      chk("byte7 in_ready", 64'(in_ready), 64'd1);

      // 21 lanes with backpressure on the first block
      exp_blk = '0;
      for (int i = 0; i < 17; i++) begin
         send_lane(dat(i + 40), 1'b0, 4'd8);
         exp_blk = set_lane(exp_blk, i, dat(i + 40));
      end
      chk("stall first valid", 64'(block_valid), 64'd1);
      in_data  = 64'h0BAD_0BAD_0BAD_0BAD;
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_bytes = 4'd2;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk_blk("stall block stable", block, exp_blk);
         chk("stall in_ready", 64'(in_ready), 64'd0);
         chk("stall valid", 64'(block_valid), 64'd1);
      end
      chk("stall last", 64'(block_last), 64'd0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      take_block();
      exp_blk2 = '0;
      for (int i = 17; i < 20; i++) begin
         send_lane(dat(i + 40), 1'b0, 4'd8);
         exp_blk2 = set_lane(exp_blk2, i - 17, dat(i + 40));
      end
      send_lane(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
      exp_blk2 = set_lane(exp_blk2, 3, 64'h06);
      exp_blk2[63:56] = 8'h80;
      chk("stall second valid", 64'(block_valid), 64'd1);
      chk_blk("stall second block", block, exp_blk2);
      chk("stall second last", 64'(block_last), 64'd1);
      take_block();

      // Reset mid-block, then a clean message
      for (int i = 0; i < 9; i++) begin
         send_lane(dat(i + 100), 1'b0, 4'd8);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset valid", 64'(block_valid), 64'd0);
      chk("midreset in_ready", 64'(in_ready), 64'd1);
      chk("midreset lane_idx", 64'(dut.lane_idx_q), 64'd0);
      chk_blk("midreset block", block, '0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_lane(64'h0000_0000_0063_6261, 1'b1, 4'd3);
      exp_blk = '0;
      exp_blk = set_lane(exp_blk, 0, 64'h0000_0000_0663_6261);
      exp_blk[63:56] = 8'h80;
      chk_blk("post-reset block", block, exp_blk);
      chk("post-reset last", 64'(block_last), 64'd1);
      take_block();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
